note_dispatcher: RTL and testbench
==================================

NOTE_DISPATCHER -- requirements
Module: note_dispatcher

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3: number of downstream note players served (2..8).
REQ-002 SHALL have parameter NOTE_W, default 6: note code width; DUR_W, default 6: duration width in beats.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port play_enable  in  1  high = run, low = pause.
REQ-006 SHALL have port beat  in  1  one-cycle 1/48 s tick.
REQ-007 SHALL have port item_valid  in  1  song item offered.
REQ-008 SHALL have port item_is_wait  in  1  1 = timing-advance item, 0 = note item.
REQ-009 SHALL have port item_note  in  NOTE_W  note code; item_duration  in  DUR_W  beats.
REQ-010 SHALL have port item_ready  out  1  item accepted when item_valid & item_ready.
REQ-011 SHALL have port voice_load  out  NUM_VOICES  one-hot, one-cycle load pulse per voice.
REQ-012 SHALL have port voice_note  out  NOTE_W  and voice_duration  out  DUR_W  shared registered load bus.
REQ-013 SHALL have port voice_done  in  NUM_VOICES  per-voice level done from each player.
REQ-014 SHALL have port voice_busy  out  NUM_VOICES  registered occupancy mask.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT.
REQ-016 SHALL go IDLE->FETCH on the cycle after play_enable is high; FETCH/WAIT hold state, counter, and outputs while play_enable is low.
REQ-017 SHALL drive item_ready = (state==FETCH) & play_enable & (any voice free, i.e. ~voice_busy nonzero); depends on no item_* input.
REQ-018 SHALL, on an accepted note item with duration != 0, pulse voice_load[i] on the next cycle for the lowest-index free voice i, with voice_note/voice_duration valid that cycle and held until the next load.
REQ-019 SHALL set voice_busy[i] on the cycle voice_load[i] pulses, and clear it on a rising edge of voice_done[i] (registered previous value).
REQ-020 SHALL give set priority over clear when both occur for the same voice in one cycle.
REQ-021 SHALL accept note items with duration 0 without issuing any load or changing voice_busy.
REQ-022 SHALL, on an accepted wait item, load the wait counter with item_duration and enter WAIT.
REQ-023 SHALL, in WAIT, decrement the counter on each beat while play_enable is high, and return to FETCH the cycle after the counter is 0; a wait of 0 returns next cycle.
REQ-024 SHALL accept at most one item per cycle; back-to-back note items SHALL dispatch on consecutive cycles.
REQ-025 SHALL hold voice_load at 0 in IDLE and WAIT.

Reset
REQ-026 SHALL, on reset, return the state to IDLE and clear wait counter, voice_busy, voice_load, voice_note, voice_duration, done-edge registers, and the steal pointer.
REQ-027 SHALL drive item_ready 0 during and on the cycle after reset.
REQ-028 SHALL let reset mid-WAIT or mid-dispatch abandon the operation; no load pulse issues after reset.

Configuration
REQ-029 SHALL, with VOICE_STEAL_EN defined, hold item_ready high in FETCH (while play_enable) even when all voices are busy, and dispatch such a note to the voice at a round-robin steal pointer that advances modulo NUM_VOICES per steal.
REQ-030 SHALL, with VOICE_STEAL_EN undefined, omit the steal pointer, and item_ready SHALL follow REQ-017 exactly.

Structure
REQ-031 SHALL take NOTE_W, DUR_W, and the FSM state encoding from the shared package synth_pkg.
REQ-032 SHALL instantiate one sub-module, free_voice_picker: a lowest-index priority encoder over ~voice_busy giving a one-hot grant and an any_free flag.

Verification
REQ-033 SHALL cover: reset, then play_enable=1 and note item (note 12, dur 8) -> voice_load=001 one cycle after accept, voice_note=12, voice_busy=001.
REQ-034 SHALL cover: three back-to-back notes, then a fourth -> loads 001,010,100 on consecutive cycles; without VOICE_STEAL_EN item_ready=0 until a voice_done rising edge frees a voice.
REQ-035 SHALL cover: wait item dur 3 with play_enable toggled low for 10 beats midway -> FETCH re-entered only after 3 beats counted while enabled.
REQ-036 SHALL cover: note item with duration 0 -> accepted, voice_load stays 0, voice_busy unchanged.
REQ-037 SHALL cover: VOICE_STEAL_EN with all busy and 4 further notes -> loads 001,010,100,001.
REQ-038 SHALL cover: reset asserted in WAIT with counter 5 -> next cycle state IDLE, all outputs 0.

Source files
------------

// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the note dispatcher:
//   NOTE_W  - default note code width
//   DUR_W   - default duration width (beats)
//   state_e - dispatcher FSM state encoding (IDLE, FETCH, WAIT)
// ---------------------------------------------------------------------------
package synth_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/note_dispatcher_free_voice_picker.sv
// ---------------------------------------------------------------------------
// free_voice_picker
// Lowest-index priority encoder over the free voices (~busy_i).
// Ports:
//   busy_i     - per-voice occupancy mask
//   grant_o    - one-hot select of the lowest-index free voice (0 if none)
//   any_free_o - high when at least one voice is free
// ---------------------------------------------------------------------------
module free_voice_picker #(
  parameter int NUM_VOICES = 3
) (
  input  logic [NUM_VOICES-1:0] busy_i,
  output logic [NUM_VOICES-1:0] grant_o,
  output logic                  any_free_o
);

  logic [NUM_VOICES-1:0] free;

  assign free = ~busy_i;

  // x & -x isolates the lowest set bit: the lowest-index free voice.
  assign grant_o    = free & (~free + NUM_VOICES'(1));
  assign any_free_o = |free;

endmodule

// File: rtl/note_dispatcher.sv
// ---------------------------------------------------------------------------
// note_dispatcher
// Pulls song items from a valid/ready stream and hands note items to a pool
// of note players; wait items stall the stream for a number of beats.
// Optional build macro: VOICE_STEAL_EN - when defined, notes are still
// accepted with every voice busy and go to a round-robin steal pointer.
// Ports:
//   clk, reset       - single clock, synchronous active-high reset
//   play_enable      - run (1) / pause (0)
//   beat             - one-cycle beat tick
//   item_*           - song item stream (valid/ready handshake)
//   voice_load       - one-hot one-cycle load pulse per voice
//   voice_note/_duration - shared registered load bus
//   voice_done       - per-voice done level from the players
//   voice_busy       - registered occupancy mask
// ---------------------------------------------------------------------------
module note_dispatcher #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = synth_pkg::NOTE_W,
  parameter int DUR_W      = synth_pkg::DUR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  beat,
  input  logic                  item_valid,
  input  logic                  item_is_wait,
  input  logic [NOTE_W-1:0]     item_note,
  input  logic [DUR_W-1:0]      item_duration,
  output logic                  item_ready,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_duration,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_busy
);

  import synth_pkg::*;

  state_e                state_q;
  logic [DUR_W-1:0]      cnt_q;
  logic [NUM_VOICES-1:0] load_q, load_d;
  logic [NUM_VOICES-1:0] busy_q, busy_d;
  logic [NUM_VOICES-1:0] done_q;
  logic [NOTE_W-1:0]     note_q;
  logic [DUR_W-1:0]      dur_q;

  logic [NUM_VOICES-1:0] grant;
  logic [NUM_VOICES-1:0] target;
  logic [NUM_VOICES-1:0] done_rise;
  logic                  any_free;
  logic                  slot_avail;
  logic                  accept;
  logic                  note_go;
  logic                  wait_go;

  free_voice_picker #(
    .NUM_VOICES (NUM_VOICES)
  ) u_picker (
    .busy_i     (busy_q),
    .grant_o    (grant),
    .any_free_o (any_free)
  );

`ifdef VOICE_STEAL_EN
  localparam int                PTR_W      = $clog2(NUM_VOICES);
  localparam logic [PTR_W-1:0]  STEAL_LAST = PTR_W'(NUM_VOICES - 1);

  logic [PTR_W-1:0] steal_q;

  // With stealing there is always somewhere to put a note.
  assign slot_avail = 1'b1;
  assign target     = any_free ? grant : (NUM_VOICES'(1) << steal_q);
`else
  assign slot_avail = any_free;
  assign target     = grant;
`endif

  // Gated by reset so the stream is stalled during the reset cycle itself,
  // regardless of the state left over from before reset.
  assign item_ready = ~reset & play_enable & (state_q == FETCH) & slot_avail;

  assign accept    = item_valid & item_ready;
  assign note_go   = accept & ~item_is_wait & (item_duration != '0);
  assign wait_go   = accept & item_is_wait;
  assign done_rise = voice_done & ~done_q;

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    load_d = '0;
    if (note_go) load_d = target;
    // Set after clear so a load wins over a same-cycle done edge.
    busy_d = (busy_q & ~done_rise) | load_d;
  end

  // NOTE: sequential state is assigned with <= only, so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
`ifdef VOICE_STEAL_EN
      steal_q <= '0;
`endif
    end else begin
      done_q <= voice_done;
      load_q <= load_d;
      busy_q <= busy_d;

      if (note_go) begin
        note_q <= item_note;
        dur_q  <= item_duration;
      end

`ifdef VOICE_STEAL_EN
      if (note_go && !any_free)
        steal_q <= (steal_q == STEAL_LAST) ? '0 : steal_q + PTR_W'(1);
`endif

      case (state_q)
        IDLE: begin
          if (play_enable) state_q <= FETCH;
        end
        FETCH: begin
          if (wait_go) begin
            cnt_q   <= item_duration;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Paused: hold both state and counter.
          if (play_enable) begin
            if (cnt_q == '0)
              state_q <= FETCH;
            else if (beat)
              cnt_q <= cnt_q - DUR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign voice_load     = load_q;
  assign voice_busy     = busy_q;
  assign voice_note     = note_q;
  assign voice_duration = dur_q;

endmodule

// File: tb/tb_note_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_note_dispatcher
// Directed bench for note_dispatcher (NUM_VOICES=3, NOTE_W=DUR_W=6).
// A per-cycle vector table covers dispatch, voice exhaustion, done-edge
// release, zero-duration notes and set-over-clear; hand-written sequences
// cover waits with pause, zero waits, reset mid-operation and voice steal.
// ---------------------------------------------------------------------------
module tb_note_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_enable;
  logic       beat;
  logic       item_valid;
  logic       item_is_wait;
  logic [5:0] item_note;
  logic [5:0] item_duration;
  logic       item_ready;
  logic [2:0] voice_load;
  logic [5:0] voice_note;
  logic [5:0] voice_duration;
  logic [2:0] voice_done;
  logic [2:0] voice_busy;

  int total = 0;
  int bad   = 0;

  note_dispatcher dut (
    .clk            (clk),
    .reset          (reset),
    .play_enable    (play_enable),
    .beat           (beat),
    .item_valid     (item_valid),
    .item_is_wait   (item_is_wait),
    .item_note      (item_note),
    .item_duration  (item_duration),
    .item_ready     (item_ready),
    .voice_load     (voice_load),
    .voice_note     (voice_note),
    .voice_duration (voice_duration),
    .voice_done     (voice_done),
    .voice_busy     (voice_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pe;
    logic       valid;
    logic [5:0] note;
    logic [5:0] dur;
    logic [2:0] done;
    logic       exp_ready;
    logic [2:0] exp_load;
    logic [2:0] exp_busy;
    logic [5:0] exp_note;
    logic [5:0] exp_dur;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic pe, input logic valid,
                              input int note, input int dur, input int done,
                              input logic er, input int el, input int eb,
                              input int en, input int ed);
    vec_t v;
    v.pe = pe; v.valid = valid; v.note = 6'(note); v.dur = 6'(dur);
    v.done = 3'(done); v.exp_ready = er; v.exp_load = 3'(el);
    v.exp_busy = 3'(eb); v.exp_note = 6'(en); v.exp_dur = 6'(ed);
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pe, input logic valid, input logic is_wait,
                       input int note, input int dur);
    play_enable   = pe;
    item_valid    = valid;
    item_is_wait  = is_wait;
    item_note     = 6'(note);
    item_duration = 6'(dur);
  endtask

  // Reset for two cycles, then enable so the FSM sits in FETCH, all free.
  task automatic restart();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    beat = 1'b0;
    voice_done = '0;
    step();
    step();
    reset = 1'b0;
    play_enable = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] steal_exp [7];

    // Row expectations are the outputs seen before that row's clock edge.
    //            pe  vld note dur done | rdy load busy note dur
    tbl[0]  = mk(0, 0,  0, 0, 0, 0, 0, 0,  0, 0);
    tbl[1]  = mk(1, 0,  0, 0, 0, 0, 0, 0,  0, 0);
    tbl[2]  = mk(1, 1, 12, 8, 0, 1, 0, 0,  0, 0);
    tbl[3]  = mk(1, 1, 20, 5, 0, 1, 1, 1, 12, 8);
    tbl[4]  = mk(1, 1, 33, 7, 0, 1, 2, 3, 20, 5);
    tbl[5]  = mk(1, 1, 40, 9, 0, 0, 4, 7, 33, 7);
    tbl[6]  = mk(1, 1, 40, 9, 2, 0, 0, 7, 33, 7);
    tbl[7]  = mk(1, 1, 40, 9, 2, 1, 0, 5, 33, 7);
    tbl[8]  = mk(1, 0,  0, 0, 2, 0, 2, 7, 40, 9);
    tbl[9]  = mk(1, 0,  0, 0, 0, 0, 0, 7, 40, 9);
    tbl[10] = mk(1, 0,  0, 0, 1, 0, 0, 7, 40, 9);
    tbl[11] = mk(1, 1, 50, 0, 1, 1, 0, 6, 40, 9);
    tbl[12] = mk(1, 0,  0, 0, 0, 1, 0, 6, 40, 9);
    tbl[13] = mk(1, 1, 60, 3, 1, 1, 0, 6, 40, 9);
    tbl[14] = mk(1, 0,  0, 0, 1, 0, 1, 7, 60, 3);
    tbl[15] = mk(1, 0,  0, 0, 0, 0, 0, 7, 60, 3);
    tbl[16] = mk(1, 0,  0, 0, 7, 0, 0, 7, 60, 3);
    tbl[17] = mk(1, 0,  0, 0, 7, 1, 0, 0, 60, 3);

    steal_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

    // ---- reset state ----
    reset = 1'b1;
    beat = 1'b0;
    voice_done = '0;
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    step();
    step();
    check("reset_ready", int'(item_ready), 0);
    check("reset_load", int'(voice_load), 0);
    check("reset_busy", int'(voice_busy), 0);
    reset = 1'b0;
    play_enable = 1'b0;

`ifndef VOICE_STEAL_EN
    // ---- table: dispatch, exhaustion, done edges, zero duration ----
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].pe, tbl[i].valid, 1'b0, int'(tbl[i].note), int'(tbl[i].dur));
      voice_done = tbl[i].done;
      #1;
      check($sformatf("row%0d_ready", i), int'(item_ready), int'(tbl[i].exp_ready));
      check($sformatf("row%0d_load", i), int'(voice_load), int'(tbl[i].exp_load));
      check($sformatf("row%0d_busy", i), int'(voice_busy), int'(tbl[i].exp_busy));
      check($sformatf("row%0d_note", i), int'(voice_note), int'(tbl[i].exp_note));
      check($sformatf("row%0d_dur", i), int'(voice_duration), int'(tbl[i].exp_dur));
      step();
    end
    voice_done = '0;
`else
    // ---- steal: three notes fill the pool, four more rotate ----
    restart();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, i + 1, 2);
      #1;
      check($sformatf("steal%0d_ready", i), int'(item_ready), 1);
      step();
      check($sformatf("steal%0d_load", i), int'(voice_load), int'(steal_exp[i]));
      check($sformatf("steal%0d_note", i), int'(voice_note), i + 1);
    end
    check("steal_busy", int'(voice_busy), 7);
`endif

    // ---- wait of 3 beats with a 10-beat pause in the middle ----
    restart();
    drive(1'b1, 1'b1, 1'b1, 0, 3);
    #1;
    check("wait3_accept_ready", int'(item_ready), 1);
    step();
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    #1;
    check("wait3_in_wait", int'(item_ready), 0);
    beat = 1'b1;
    step();
    beat = 1'b0;
    play_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat = 1'b1;
      step();
      beat = 1'b0;
      step();
    end
    play_enable = 1'b1;
    #1;
    check("wait3_paused_hold", int'(item_ready), 0);
    step();
    #1;
    check("wait3_after_resume", int'(item_ready), 0);
    beat = 1'b1;
    step();
    step();
    beat = 1'b0;
    #1;
    check("wait3_count_zero", int'(item_ready), 0);
    check("wait3_no_load", int'(voice_load), 0);
    step();
    check("wait3_back_fetch", int'(item_ready), 1);

    // ---- wait of 0 returns the cycle after ----
    drive(1'b1, 1'b1, 1'b1, 0, 0);
    step();
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    #1;
    check("wait0_in_wait", int'(item_ready), 0);
    step();
    check("wait0_back_fetch", int'(item_ready), 1);

    // ---- reset in WAIT with counter 5 ----
    restart();
    drive(1'b1, 1'b1, 1'b0, 7, 4);
    step();
    drive(1'b1, 1'b1, 1'b1, 0, 5);
    step();
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    #1;
    check("rstwait_pre_busy", int'(voice_busy), 1);
    check("rstwait_pre_ready", int'(item_ready), 0);
    reset = 1'b1;
    step();
    check("rstwait_ready", int'(item_ready), 0);
    check("rstwait_load", int'(voice_load), 0);
    check("rstwait_busy", int'(voice_busy), 0);
    check("rstwait_note", int'(voice_note), 0);
    check("rstwait_dur", int'(voice_duration), 0);
    reset = 1'b0;
    #1;
    check("rstwait_after_ready", int'(item_ready), 0);
    step();
    check("rstwait_fetch_ready", int'(item_ready), 1);

    // ---- reset coinciding with an offered note: nothing dispatches ----
    drive(1'b1, 1'b1, 1'b0, 9, 3);
    reset = 1'b1;
    #1;
    check("rstdisp_ready", int'(item_ready), 0);
    step();
    check("rstdisp_load", int'(voice_load), 0);
    check("rstdisp_busy", int'(voice_busy), 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
